// File: rtl/fmp_pkg.sv
// Shared types and helpers for the finite_mod_pipe block.
//   fmp_mode_e : per-sample operating mode (constant offset or running sum)
//   mod_add    : modular addition of two residues by one conditional subtract.
//                Both operands must already be < m, so one subtract is enough.
package fmp_pkg;

    typedef enum logic {
        FMP_OFFSET = 1'b0,
        FMP_ACCUM  = 1'b1
    } fmp_mode_e;

    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] m);
        logic [31:0] s;
        s = a + b;
        return (s >= m) ? (s - m) : s;
    endfunction

endpackage

// File: rtl/mod_reduce.sv
// Combinational reduction of an unsigned sample into Z/MOD.
// Ports:
//   data_i : IN_W-bit unsigned sample
//   rem_o  : data_i % MOD, OUT_W bits, always < MOD
module mod_reduce
    import fmp_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int MOD   = 20,
    parameter int OUT_W = $clog2(MOD)
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] rem_o
);

    // The remainder is < MOD <= 2**OUT_W, so the narrowing cast is lossless.
    assign rem_o = OUT_W'(32'(data_i) % 32'(MOD));

endmodule

// File: rtl/finite_mod_pipe.sv
// Streaming modular-arithmetic unit over Z/MOD with a 2-stage pipeline.
// Each accepted sample is reduced mod MOD (stage 1), then either offset by
// OFFSET or added into a running modular accumulator (stage 2).
// Optional feature macro: FMP_WRAP_CNT_EN adds a saturating wrap counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_data + in_mode travel together
//   clear               : synchronous accumulator clear (honoured while stalled)
//   out_valid/out_ready : output handshake; out_data held while stalled
//   wrap_cnt            : count of results whose raw sum reached MOD
//                         (present only with FMP_WRAP_CNT_EN)
module finite_mod_pipe
    import fmp_pkg::*;
#(
    parameter int IN_W   = 7,
    parameter int MOD    = 20,
    parameter int OFFSET = 6,
    parameter int OUT_W  = $clog2(MOD),
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_mode,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data
`ifdef FMP_WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    if (MOD < 2 || MOD > (1 << IN_W) || OFFSET < 0 || OFFSET >= MOD ||
        WRAP_W < 1 || OUT_W != $clog2(MOD)) begin : g_param_chk
        $error("finite_mod_pipe: illegal parameter combination");
    end

    logic             stall;
    logic             accept;
    logic [OUT_W-1:0] red;

    logic [OUT_W-1:0] r_p1_q;
    fmp_mode_e        mode_p1_q;
    logic             vld_p1_q;

    logic [OUT_W-1:0] out_data_p2_q;
    logic             vld_p2_q;
    logic [OUT_W-1:0] acc_q;

    logic [OUT_W-1:0] acc_eff;
    logic [OUT_W-1:0] addend;
    logic [OUT_W-1:0] res_p1;
    logic             adv_p1;
    logic             acc_adv;

    // Global stall: a held result blocks every stage, including the input.
    assign stall     = vld_p2_q & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_p2_q;
    assign out_data  = out_data_p2_q;

    mod_reduce #(
        .IN_W  (IN_W),
        .MOD   (MOD),
        .OUT_W (OUT_W)
    ) u_reduce (
        .data_i (in_data),
        .rem_o  (red)
    );

    always_comb begin
        acc_eff = clear ? '0 : acc_q;
        addend  = (mode_p1_q == FMP_ACCUM) ? acc_eff : OUT_W'(OFFSET);
        res_p1  = OUT_W'(mod_add(32'(r_p1_q), 32'(addend), 32'(MOD)));
        adv_p1  = ~stall & vld_p1_q;
        acc_adv = adv_p1 & (mode_p1_q == FMP_ACCUM);
    end

    // ---- stage 1: reduced sample register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (accept) begin
            vld_p1_q <= 1'b1;
        end else if (!stall) begin
            vld_p1_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            r_p1_q    <= red;
            mode_p1_q <= fmp_mode_e'(in_mode);
        end
    end

    // ---- stage 2: result register and accumulator ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q      <= 1'b0;
            out_data_p2_q <= '0;
        end else if (!stall) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                out_data_p2_q <= res_p1;
            end
        end
    end

    // An advancing ACCUM sample already sees acc_eff = 0 under clear, so its
    // result is the correct post-clear accumulator value.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (acc_adv) begin
            acc_q <= res_p1;
        end else if (clear) begin
            acc_q <= '0;
        end
    end

`ifdef FMP_WRAP_CNT_EN
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic              wrap_p1;

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (&v) ? v : (v + WRAP_W'(1));
    endfunction

    assign wrap_p1 = (32'(r_p1_q) + 32'(addend)) >= 32'(MOD);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wrap_cnt_q <= '0;
        end else if (adv_p1 && wrap_p1) begin
            wrap_cnt_q <= sat_inc(wrap_cnt_q);
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_finite_mod_pipe.sv
// Directed bench for finite_mod_pipe with MOD=20, OFFSET=6, IN_W=7.
module tb_finite_mod_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_mode;
    logic       clear;
    logic       out_ready;
    logic [6:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_data;
`ifdef FMP_WRAP_CNT_EN
    logic [7:0] wrap_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    finite_mod_pipe #(
        .IN_W   (7),
        .MOD    (20),
        .OFFSET (6),
        .WRAP_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FMP_WRAP_CNT_EN
        ,
        .wrap_cnt  (wrap_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, pass one rising edge, settle 1 time unit after it.
    task automatic drive(input logic v, input logic [6:0] d, input logic m, input logic c);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        clear = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef FMP_WRAP_CNT_EN
        check("rst_wrap_cnt", wrap_cnt, 0);
`endif

        // OFFSET stream
        drive(1, 127, 0, 0); check("t1_latency", out_valid, 0);
        drive(1, 14, 0, 0);  check("t1_v0", out_valid, 1); check("t1_d0", out_data, 13);
        drive(1, 0, 0, 0);   check("t1_v1", out_valid, 1); check("t1_d1", out_data, 0);
        drive(0, 0, 0, 0);   check("t1_v2", out_valid, 1); check("t1_d2", out_data, 6);
        drive(0, 0, 0, 0);   check("t1_drain", out_valid, 0);

        // ACCUM stream with an interleaved OFFSET sample
        drive(1, 15, 1, 0);
        drive(1, 7, 1, 0);   check("t2_d0", out_data, 15);
        drive(1, 19, 1, 0);  check("t2_d1", out_data, 2);
        drive(1, 3, 0, 0);   check("t2_d2", out_data, 1);
        drive(1, 4, 1, 0);   check("t2_off", out_data, 9);
        drive(0, 0, 0, 0);   check("t2_keep", out_data, 5); check("t2_kv", out_valid, 1);
        drive(0, 0, 0, 0);   check("t2_drain", out_valid, 0);

        // clear: acc 5 -> 17, then ACCUM 8 enters S2 together with clear
        drive(1, 12, 1, 0);
        drive(1, 8, 1, 0);   check("t3_acc17", out_data, 17);
        drive(0, 0, 0, 1);   check("t3_clr_adv", out_data, 8);
        drive(1, 5, 0, 0);   check("t3_gap", out_valid, 0);
        drive(0, 0, 0, 1);   check("t3_clr_off", out_data, 11);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(1, 3, 1, 0);
        drive(0, 0, 0, 0);   check("t3_clr_idle", out_data, 3);
        drive(0, 0, 0, 0);

        // backpressure
        out_ready = 1'b0;
        drive(1, 1, 0, 0);   check("t4_first", out_valid, 0);
        drive(1, 2, 0, 0);   check("t4_ready", in_ready, 0); check("t4_d", out_data, 7);
        for (int i = 0; i < 5; i++) begin
            drive(1, 3, 0, 0);
            check("t4_hold_ready", in_ready, 0);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", out_data, 7);
        end
        out_ready = 1'b1;
        drive(1, 3, 0, 0);   check("t4_rel0", out_data, 8); check("t4_rel_v", out_valid, 1);
        drive(0, 0, 0, 0);   check("t4_rel1", out_data, 9);
        drive(0, 0, 0, 0);   check("t4_drain", out_valid, 0);

        // reset mid-stream (acc is 3 here)
        drive(1, 9, 1, 0);
        drive(1, 10, 1, 0);  check("t5_pre", out_data, 12);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
        check("t5_valid", out_valid, 0);
        check("t5_data", out_data, 0);
        drive(1, 11, 1, 0);  check("t5_flush", out_valid, 0);
        drive(0, 0, 0, 0);   check("t5_acc0", out_data, 11); check("t5_v", out_valid, 1);
        drive(0, 0, 0, 0);   check("t5_drain", out_valid, 0);

`ifdef FMP_WRAP_CNT_EN
        drive(0, 0, 0, 1);
        drive(1, 19, 1, 0);
        drive(1, 19, 1, 0);  check("t6_d0", out_data, 19); check("t6_w0", wrap_cnt, 0);
        drive(1, 19, 1, 0);  check("t6_d1", out_data, 18); check("t6_w1", wrap_cnt, 1);
        drive(0, 0, 0, 0);   check("t6_d2", out_data, 17); check("t6_w2", wrap_cnt, 2);
        for (int i = 0; i < 260; i++) drive(1, 14, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);   check("t6_sat", wrap_cnt, 255);
        drive(0, 0, 0, 1);   check("t6_clr", wrap_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
